// File: rtl/conv_layer_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_sched_if
//  Description : Control/handshake bundle between the host/load logic and
//                the LeNet-5 layer sequencer. The host side drives the run
//                request, abort and load-complete strobes. The sequencer side
//                returns status, per-layer enables and the feature-BRAM row
//                address.
//                Optional macro CONV_SCHED_PERF_EN adds cycle_cnt[15:0].
//  Modports    : master - host / load logic
//                slave  - conv_layer_sched
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_layer_sched_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              abort;
    logic              load_down;
    logic              load_req;
    logic              busy;
    logic              done;
    logic [2:0]        layer_id;
    logic              C1_en;
    logic              S2_en;
    logic              C3_en;
    logic              S4_en;
    logic              C5_en;
    logic [ADDR_W-1:0] bram_addr_f;
    logic              addr_valid;
    logic [ADDR_W-1:0] out_row;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0]       cycle_cnt;
`endif

    modport master (
        output start, abort, load_down,
        input  load_req, busy, done, layer_id,
        input  C1_en, S2_en, C3_en, S4_en, C5_en,
        input  bram_addr_f, addr_valid, out_row
`ifdef CONV_SCHED_PERF_EN
        , input cycle_cnt
`endif
    );

    modport slave (
        input  start, abort, load_down,
        output load_req, busy, done, layer_id,
        output C1_en, S2_en, C3_en, S4_en, C5_en,
        output bram_addr_f, addr_valid, out_row
`ifdef CONV_SCHED_PERF_EN
        , output cycle_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/conv_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_sched
//  Description : Top-level sequencer for the LeNet-5 conv/pool datapath.
//                IDLE -> LOAD (host handshake) -> C1 -> S2 -> C3 -> S4 -> C5
//                -> DONE -> IDLE. Each layer issues its row addresses and then
//                drains for PIPE_LAT cycles. The next layer follows the last
//                drain cycle without a bubble.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-low reset
//                ctl  - conv_layer_sched_if.slave (start/abort/load_down in;
//                       load_req, busy, done, layer_id, C*/S*_en,
//                       bram_addr_f, addr_valid, out_row out)
//  Option      : CONV_SCHED_PERF_EN adds ctl.cycle_cnt (busy-cycle counter)
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sched #(
    parameter int IMAGE       = 32,
    parameter int KERNEL_SIZE = 5,
    parameter int ADDR_W      = $clog2(IMAGE + 1),
    parameter int PIPE_LAT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    conv_layer_sched_if.slave   ctl
);

    // Layer input heights, fixed at elaboration.
    localparam int c_N1 = IMAGE;
    localparam int c_N2 = c_N1 - KERNEL_SIZE + 1;
    localparam int c_N3 = c_N2 / 2;
    localparam int c_N4 = c_N3 - KERNEL_SIZE + 1;
    localparam int c_N5 = c_N4 / 2;

    // Final row-counter value per layer. Conv layers stop at N-K and pool
    // layers stop at N-1.
    localparam logic [ADDR_W-1:0] c_C1_LAST = ADDR_W'(c_N1 - KERNEL_SIZE);
    localparam logic [ADDR_W-1:0] c_S2_LAST = ADDR_W'(c_N2 - 1);
    localparam logic [ADDR_W-1:0] c_C3_LAST = ADDR_W'(c_N3 - KERNEL_SIZE);
    localparam logic [ADDR_W-1:0] c_S4_LAST = ADDR_W'(c_N4 - 1);
    localparam logic [ADDR_W-1:0] c_C5_LAST = ADDR_W'(c_N5 - KERNEL_SIZE);
    localparam logic [ADDR_W-1:0] c_K_LAST  = ADDR_W'(KERNEL_SIZE - 1);

    localparam int              c_DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [c_DW-1:0] c_D_LAST = c_DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_C1   = 3'd2,
        S_S2   = 3'd3,
        S_C3   = 3'd4,
        S_S4   = 3'd5,
        S_C5   = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t            r_state, w_state;
    logic              r_drain, w_drain;
    logic [ADDR_W-1:0] r_row,   w_row;
    logic [ADDR_W-1:0] r_k,     w_k;
    logic [c_DW-1:0]   r_dcnt,  w_dcnt;

    logic              w_is_conv;
    logic [ADDR_W-1:0] w_last_row;
    logic              w_last_issue;
    logic              w_advance;

    // Next-cycle output values; outputs are registered from these.
    logic [2:0]        w_layer_id;
    logic              w_nxt_conv;
    logic              w_issue;
    logic [4:0]        w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_out_row;

    logic              r_load_req, r_busy, r_done, r_addr_valid;
    logic [2:0]        r_layer_id;
    logic [4:0]        r_en;
    logic [ADDR_W-1:0] r_addr, r_out_row;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state    = r_state;
        w_drain    = r_drain;
        w_row      = r_row;
        w_k        = r_k;
        w_dcnt     = r_dcnt;
        w_advance  = 1'b0;
        w_is_conv  = 1'b0;
        w_last_row = '0;

        case (r_state)
            S_C1:    begin w_is_conv = 1'b1; w_last_row = c_C1_LAST; end
            S_S2:    begin w_is_conv = 1'b0; w_last_row = c_S2_LAST; end
            S_C3:    begin w_is_conv = 1'b1; w_last_row = c_C3_LAST; end
            S_S4:    begin w_is_conv = 1'b0; w_last_row = c_S4_LAST; end
            S_C5:    begin w_is_conv = 1'b1; w_last_row = c_C5_LAST; end
            default: ;
        endcase

        w_last_issue = (r_row == w_last_row) && (!w_is_conv || (r_k == c_K_LAST));

        case (r_state)
            S_IDLE: begin
                if (ctl.start && !ctl.abort) w_state = S_LOAD;
            end
            S_LOAD: begin
                if (ctl.load_down) begin
                    w_state = S_C1;
                    w_row   = '0;
                    w_k     = '0;
                    w_drain = 1'b0;
                    w_dcnt  = '0;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                if (!r_drain) begin
                    if (w_last_issue) begin
                        if (PIPE_LAT == 0) begin
                            w_advance = 1'b1;
                        end else begin
                            w_drain = 1'b1;
                            w_dcnt  = '0;
                        end
                    end else if (w_is_conv && (r_k != c_K_LAST)) begin
                        w_k = r_k + 1'b1;
                    end else begin
                        // k is the inner loop; pool layers keep k at 0.
                        w_k   = '0;
                        w_row = r_row + 1'b1;
                    end
                end else if (r_dcnt == c_D_LAST) begin
                    w_advance = 1'b1;
                end else begin
                    w_dcnt = r_dcnt + 1'b1;
                end

                if (w_advance) begin
                    w_row   = '0;
                    w_k     = '0;
                    w_drain = 1'b0;
                    w_dcnt  = '0;
                    case (r_state)
                        S_C1:    w_state = S_S2;
                        S_S2:    w_state = S_C3;
                        S_C3:    w_state = S_S4;
                        S_S4:    w_state = S_C5;
                        S_C5:    w_state = S_DONE;
                        default: w_state = S_IDLE;
                    endcase
                end
            end
        endcase

        // Abort overrides any load handshake or layer transition.
        if ((r_state != S_IDLE) && ctl.abort) begin
            w_state = S_IDLE;
            w_row   = '0;
            w_k     = '0;
            w_drain = 1'b0;
            w_dcnt  = '0;
        end

        w_nxt_conv = 1'b0;
        case (w_state)
            S_C1:    begin w_layer_id = 3'd1; w_nxt_conv = 1'b1; end
            S_S2:    w_layer_id = 3'd2;
            S_C3:    begin w_layer_id = 3'd3; w_nxt_conv = 1'b1; end
            S_S4:    w_layer_id = 3'd4;
            S_C5:    begin w_layer_id = 3'd5; w_nxt_conv = 1'b1; end
            default: w_layer_id = 3'd0;
        endcase

        w_issue = (w_layer_id != 3'd0) && !w_drain;

        w_en[0] = w_issue && (w_state == S_C1);
        w_en[1] = w_issue && (w_state == S_S2);
        w_en[2] = w_issue && (w_state == S_C3);
        w_en[3] = w_issue && (w_state == S_S4);
        w_en[4] = w_issue && (w_state == S_C5);

        // Address and row index are held through drain and DONE, zero before C1.
        w_addr    = r_addr;
        w_out_row = r_out_row;
        if ((w_state == S_IDLE) || (w_state == S_LOAD)) begin
            w_addr    = '0;
            w_out_row = '0;
        end else if (w_issue) begin
            w_addr    = w_nxt_conv ? (w_row + w_k) : w_row;
            w_out_row = w_nxt_conv ? w_row : (w_row >> 1);
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_drain      <= 1'b0;
            r_row        <= '0;
            r_k          <= '0;
            r_dcnt       <= '0;
            r_load_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_layer_id   <= 3'd0;
            r_en         <= '0;
            r_addr_valid <= 1'b0;
            r_addr       <= '0;
            r_out_row    <= '0;
        end else begin
            r_state      <= w_state;
            r_drain      <= w_drain;
            r_row        <= w_row;
            r_k          <= w_k;
            r_dcnt       <= w_dcnt;
            r_load_req   <= (w_state == S_LOAD);
            r_busy       <= (w_state != S_IDLE);
            r_done       <= (w_state == S_DONE);
            r_layer_id   <= w_layer_id;
            r_en         <= w_en;
            r_addr_valid <= w_issue;
            r_addr       <= w_addr;
            r_out_row    <= w_out_row;
        end
    end

    assign ctl.load_req    = r_load_req;
    assign ctl.busy        = r_busy;
    assign ctl.done        = r_done;
    assign ctl.layer_id    = r_layer_id;
    assign ctl.C1_en       = r_en[0];
    assign ctl.S2_en       = r_en[1];
    assign ctl.C3_en       = r_en[2];
    assign ctl.S4_en       = r_en[3];
    assign ctl.C5_en       = r_en[4];
    assign ctl.addr_valid  = r_addr_valid;
    assign ctl.bram_addr_f = r_addr;
    assign ctl.out_row     = r_out_row;

`ifdef CONV_SCHED_PERF_EN
    // The count includes the current busy cycle. The accepting edge
    // therefore loads 1, and the value equals the cycle index when DONE is reached.
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_state == S_LOAD) r_cycle_cnt <= 16'd1;
        end else if (ctl.abort) begin
            r_cycle_cnt <= '0;
        end else if ((w_state != S_IDLE) && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign ctl.cycle_cnt = r_cycle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_layer_sched
//  Description : Directed self-checking bench for conv_layer_sched. Expected
//                values are hand-derived from the layer schedule (C1 occupies
//                142 cycles, S2 30, C3 52, S4 12 and C5 7). With load_down at
//                cycle 10, done falls on cycle 254.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sched;

    localparam int ADDR_W = 6;
    localparam int c_OW   = 12 + 2 * ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    conv_layer_sched_if #(.ADDR_W(ADDR_W)) bus ();

    conv_layer_sched #(
        .IMAGE       (32),
        .KERNEL_SIZE (5),
        .ADDR_W      (ADDR_W),
        .PIPE_LAT    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [c_OW-1:0] outs();
        return {bus.load_req, bus.busy, bus.done, bus.layer_id,
                bus.C1_en, bus.S2_en, bus.C3_en, bus.S4_en, bus.C5_en,
                bus.addr_valid, bus.bram_addr_f, bus.out_row};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Start at cycle 0, load_down sampled at cycle load_at; returns in cycle load_at+1.
    task automatic begin_run(input int load_at);
        cyc = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (cyc < load_at) step();
        bus.load_down = 1'b1;
        step();
        bus.load_down = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", outs());
        end
        rst = 1'b1;
        step();
        step();
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h, want 0", outs());
        end
    endtask

    task automatic test_full_run();
        int cnt[5];
        int done_cyc;
        int bad_hot;
        int bad_id;
        logic [4:0] en;
        int want_cnt[5] = '{140, 28, 50, 10, 5};
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        done_cyc = -1;
        bad_hot  = 0;
        bad_id   = 0;

        cyc = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.load_req !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_req_c1: got req=%b busy=%b, want 1 1", bus.load_req, bus.busy);
        end
        while (cyc < 10) step();
        bus.load_down = 1'b1;
        checks++;
        if (bus.load_req !== 1'b1 || bus.C1_en !== 1'b0) begin
            errors++;
            $display("FAIL load_wait_c10: got req=%b C1_en=%b, want 1 0", bus.load_req, bus.C1_en);
        end
        step();
        bus.load_down = 1'b0;
        checks++;
        if (bus.C1_en !== 1'b1 || bus.load_req !== 1'b0 || bus.layer_id !== 3'd1) begin
            errors++;
            $display("FAIL c1_start_c11: got C1_en=%b req=%b id=%0d, want 1 0 1",
                     bus.C1_en, bus.load_req, bus.layer_id);
        end

        while (cyc < 256) begin
            en = {bus.C5_en, bus.S4_en, bus.C3_en, bus.S2_en, bus.C1_en};
            if ($countones(en) > 1) bad_hot++;
            for (int i = 0; i < 5; i++) begin
                if (en[i] === 1'b1) begin
                    cnt[i]++;
                    if (bus.layer_id !== 3'(i + 1)) bad_id++;
                end
            end
            if (bus.done === 1'b1 && done_cyc < 0) begin
                done_cyc = cyc;
`ifdef CONV_SCHED_PERF_EN
                checks++;
                if (bus.cycle_cnt !== 16'd254) begin
                    errors++;
                    $display("FAIL cycle_cnt_at_done: got %0d, want 254", bus.cycle_cnt);
                end
`endif
            end
            if (cyc == 255) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_c255: got %b, want 0", bus.busy);
                end
            end
            step();
        end

        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cnt[i] !== want_cnt[i]) begin
                errors++;
                $display("FAIL en_count layer %0d: got %0d, want %0d", i + 1, cnt[i], want_cnt[i]);
            end
        end
        checks++;
        if (bad_hot !== 0) begin
            errors++;
            $display("FAIL enable_onehot: got %0d multi-enable cycles, want 0", bad_hot);
        end
        checks++;
        if (bad_id !== 0) begin
            errors++;
            $display("FAIL layer_id_match: got %0d mismatched cycles, want 0", bad_id);
        end
        checks++;
        if (done_cyc !== 254) begin
            errors++;
            $display("FAIL done_cycle: got %0d, want 254", done_cyc);
        end
`ifdef CONV_SCHED_PERF_EN
        step();
        step();
        checks++;
        if (bus.cycle_cnt !== 16'd254) begin
            errors++;
            $display("FAIL cycle_cnt_hold: got %0d, want 254", bus.cycle_cnt);
        end
`endif
    endtask

    task automatic test_c1_s2_stream();
        int exp10[10] = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 5};
        int bad;
        int bad_at;
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] wr;

        begin_run(10);
        bad    = 0;
        bad_at = -1;
        for (int i = 0; i < 140; i++) begin
            wa = ADDR_W'(i / 5 + i % 5);
            wr = ADDR_W'(i / 5);
            if (i < 10) begin
                checks++;
                if (bus.bram_addr_f !== ADDR_W'(exp10[i])) begin
                    errors++;
                    $display("FAIL c1_first10 idx %0d: got %0d, want %0d", i, bus.bram_addr_f, exp10[i]);
                end
            end
            if (i == 139) begin
                checks++;
                if (bus.bram_addr_f !== 6'd31 || bus.out_row !== 6'd27) begin
                    errors++;
                    $display("FAIL c1_last_issue: got addr %0d row %0d, want 31 27",
                             bus.bram_addr_f, bus.out_row);
                end
            end
            if (bus.C1_en !== 1'b1 || bus.addr_valid !== 1'b1 ||
                bus.bram_addr_f !== wa || bus.out_row !== wr) begin
                if (bad == 0) bad_at = i;
                bad++;
            end
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL c1_stream: got %0d bad cycles (first issue %0d), want 0", bad, bad_at);
        end

        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bus.C1_en !== 1'b0 || bus.addr_valid !== 1'b0 ||
                bus.layer_id !== 3'd1 || bus.bram_addr_f !== 6'd31) begin
                errors++;
                $display("FAIL c1_drain %0d: got en=%b valid=%b id=%0d addr=%0d, want 0 0 1 31",
                         d, bus.C1_en, bus.addr_valid, bus.layer_id, bus.bram_addr_f);
            end
            step();
        end

        bad    = 0;
        bad_at = -1;
        for (int a = 0; a < 28; a++) begin
            if (bus.S2_en !== 1'b1 || bus.layer_id !== 3'd2 || bus.addr_valid !== 1'b1 ||
                bus.bram_addr_f !== ADDR_W'(a) || bus.out_row !== ADDR_W'(a / 2)) begin
                if (bad == 0) bad_at = a;
                bad++;
            end
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL s2_stream: got %0d bad cycles (first a=%0d), want 0", bad, bad_at);
        end

        for (int g = 0; g < 200 && bus.busy === 1'b1; g++) step();
    endtask

    task automatic test_abort();
        int n_c3;
        int saw_done;
        begin_run(10);
        n_c3 = 0;
        for (int g = 0; g < 300 && n_c3 < 20; g++) begin
            if (bus.C3_en === 1'b1) n_c3++;
            if (n_c3 < 20) step();
        end
        checks++;
        if (cyc !== 202 || bus.layer_id !== 3'd3) begin
            errors++;
            $display("FAIL c3_20th_cycle: got cyc %0d id %0d, want 202 3", cyc, bus.layer_id);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %h, want 0", outs());
        end
`ifdef CONV_SCHED_PERF_EN
        checks++;
        if (bus.cycle_cnt !== 16'd0) begin
            errors++;
            $display("FAIL abort_cycle_cnt: got %0d, want 0", bus.cycle_cnt);
        end
`endif
        saw_done = 0;
        for (int g = 0; g < 100; g++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done++;
            step();
        end
        checks++;
        if (saw_done !== 0) begin
            errors++;
            $display("FAIL abort_stays_idle: got %0d active cycles, want 0", saw_done);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.load_req !== 1'b1 || bus.layer_id !== 3'd0) begin
            errors++;
            $display("FAIL restart_load: got req=%b id=%0d, want 1 0", bus.load_req, bus.layer_id);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    task automatic test_abort_priority();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.load_req !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%b req=%b, want 0 0", bus.busy, bus.load_req);
        end
        bus.start = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.load_down = 1'b1;
        bus.abort     = 1'b1;
        step();
        bus.load_down = 1'b0;
        bus.abort     = 1'b0;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL abort_over_load_down: got %h, want 0", outs());
        end
    endtask

    task automatic test_start_ignored();
        begin_run(10);
        for (int g = 0; g < 300 && bus.layer_id !== 3'd2; g++) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int g = 0; g < 300 && bus.done !== 1'b1; g++) step();
        checks++;
        if (cyc !== 254 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL start_in_s2_done: got cyc %0d done=%b, want 254 1", cyc, bus.done);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_s2_idle: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        begin_run(10);
        while (cyc < 50) step();
        checks++;
        if (bus.C1_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_c1_active: got C1_en=%b, want 1", bus.C1_en);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h, want 0", outs());
        end
        step();
        rst = 1'b1;
        step();
        begin_run(10);
        for (int g = 0; g < 300 && bus.done !== 1'b1; g++) step();
        checks++;
        if (cyc !== 254) begin
            errors++;
            $display("FAIL fresh_run_after_reset: got done at %0d, want 254", cyc);
        end
        step();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.load_down = 1'b0;
        test_reset();
        test_full_run();
        test_c1_s2_stream();
        test_abort();
        test_abort_priority();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
